// File: rtl/ifft_bin_frame_packer_if.sv
// AXI-Stream style bus used for both sides of the IFFT bin frame packer.
// master drives the payload; slave returns tready. tuser is sideband from master.
interface ifft_bin_frame_packer_if #(
  parameter int DATA_W = 64
);
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic              tlast;
  logic              tuser;

  modport master (output tvalid, output tdata, output tlast, output tuser, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/ifft_bin_frame_packer.sv
// Packs serial complex bins (one per beat) into 8-bin frames for the IFFT stage.
// Optional build macro IFFT_PACK_BITREV_EN: beat k lands in slot bitrev3(k).
//
// Handshake: a beat/frame transfers on a rising edge where tvalid and tready
// are both high; tvalid/payload never depend combinationally on the same-side tready.
module ifft_bin_frame_packer #(
  parameter int C_AXIS_TDATA_WIDTH = 64,
  parameter int C_AXIS_TOUT_WIDTH  = 512
) (
  input  logic                           s_axis_aclk,
  input  logic                           s_axis_aresetn,
  ifft_bin_frame_packer_if.slave         s_axis,
  ifft_bin_frame_packer_if.master        m_axis,
  output logic                           stat_short,
  output logic                           stat_nolast,
  output logic [1:0]                     state_dbg
);
  localparam int BIN_W = C_AXIS_TDATA_WIDTH;
  localparam int NBINS = C_AXIS_TOUT_WIDTH / C_AXIS_TDATA_WIDTH;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_FILL  = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t                         state, state_next;
  logic [2:0]                     cnt;
  logic [2:0]                     slot;
  logic [NBINS-1:0][BIN_W-1:0]    asm_buf;
  logic [NBINS-1:0][BIN_W-1:0]    merged;
  logic                           hold_user;
  logic                           out_valid;
  logic                           out_user;
  logic [C_AXIS_TOUT_WIDTH-1:0]   out_data;
  logic                           accept;
  logic                           complete;
  logic                           is_short;
  logic                           slot_free;
  logic                           load_direct;
  logic                           load_hold;

`ifdef IFFT_PACK_BITREV_EN
  assign slot = {cnt[0], cnt[1], cnt[2]};
`else
  assign slot = cnt;
`endif

  assign accept    = s_axis.tvalid && (state == ST_FILL);
  assign complete  = accept && (s_axis.tlast || (cnt == 3'd7));
  assign is_short  = s_axis.tlast && (cnt != 3'd7);
  assign slot_free = !out_valid || m_axis.tready;

  // A frame starts from an all-zero buffer, so unwritten slots of a short frame are zero.
  always_comb begin
    merged       = (cnt == 3'd0) ? '0 : asm_buf;
    merged[slot] = s_axis.tdata;
  end

  always_comb begin
    state_next  = state;
    load_direct = 1'b0;
    load_hold   = 1'b0;
    unique case (state)
      ST_RESET: state_next = ST_FILL;
      ST_FILL: begin
        if (complete) begin
          if (slot_free) load_direct = 1'b1;
          else           state_next  = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (slot_free) begin
          load_hold  = 1'b1;
          state_next = ST_FILL;
        end
      end
      default: state_next = ST_RESET;
    endcase
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) state <= ST_RESET;
    else                 state <= state_next;
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      cnt         <= 3'd0;
      asm_buf     <= '0;
      hold_user   <= 1'b0;
      out_valid   <= 1'b0;
      out_user    <= 1'b0;
      out_data    <= '0;
      stat_short  <= 1'b0;
      stat_nolast <= 1'b0;
    end else begin
      if (accept) begin
        cnt     <= complete ? 3'd0 : cnt + 3'd1;
        asm_buf <= merged;
      end
      if (complete) hold_user <= is_short;

      if (load_direct) begin
        out_data  <= merged;
        out_user  <= is_short;
        out_valid <= 1'b1;
      end else if (load_hold) begin
        out_data  <= asm_buf;
        out_user  <= hold_user;
        out_valid <= 1'b1;
      end else if (m_axis.tready) begin
        out_valid <= 1'b0;
      end

      if (complete && is_short) stat_short <= 1'b1;
      if (accept && (cnt == 3'd7) && !s_axis.tlast) stat_nolast <= 1'b1;
    end
  end

  assign s_axis.tready = (state == ST_FILL);
  assign m_axis.tvalid = out_valid;
  assign m_axis.tlast  = out_valid;
  assign m_axis.tdata  = out_data;
  assign m_axis.tuser  = out_user;
  assign state_dbg     = state;
endmodule
